// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU I/O port responder: default port width,
// idle word and the TX sequencing states.
package cpu_io_pkg;

  localparam int unsigned         DW_DEFAULT        = 30;
  localparam logic [DW_DEFAULT-1:0] IDLE_WORD_DEFAULT = 30'h2100_0000;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    GAP
  } tx_state_t;

endpackage

// File: rtl/cpu_io_rx_fifo.sv
// First-word-fall-through receive FIFO holding words captured from the CPU
// output port; pointers carry one extra wrap bit to tell full from empty.
module cpu_io_rx_fifo #(
  parameter int DW    = 30,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign empty     = (wr_q == rd_q);
  assign full      = ((wr_q - rd_q) == (AW+1)'(DEPTH));
  assign head_data = mem_q[rd_q[AW-1:0]];
  assign count     = count_q;

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    count_d = wr_d - rd_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cpu_io_port_responder.sv
// External-side responder for the CPU I/O port: captures CPU output words into
// a receive FIFO for the host and paces host response words onto the CPU input.
module cpu_io_port_responder
  import cpu_io_pkg::*;
#(
  parameter int            DW        = DW_DEFAULT,
  parameter int            DEPTH     = 4,
  parameter logic [DW-1:0] IDLE_WORD = DW'(IDLE_WORD_DEFAULT),
  parameter int            MIN_GAP   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_y_valid,
  input  logic [DW-1:0]          cpu_y_data,
  output logic                   cpu_x_valid,
  output logic [DW-1:0]          cpu_x_data,
  output logic                   host_rx_valid,
  output logic [DW-1:0]          host_rx_data,
  input  logic                   host_rx_ready,
  input  logic                   host_tx_valid,
  input  logic [DW-1:0]          host_tx_data,
  output logic                   host_tx_ready,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   overflow
);

  localparam int GW = $clog2(MIN_GAP + 1);

  logic          y_q;
  logic          push;
  logic          fifo_empty;
  logic          fifo_full;
  logic          overflow_q, overflow_d;
  tx_state_t     state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [DW-1:0] x_data_q, x_data_d;

  // Only a rising edge of the CPU strobe is a new word.
  assign push = cpu_y_valid && !y_q;

  cpu_io_rx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cpu_y_data),
    .pop       (host_rx_ready),
    .head_data (host_rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (rx_count)
  );

  assign host_rx_valid = !fifo_empty;
  assign overflow      = overflow_q;
  assign cpu_x_data    = x_data_q;

  always_comb begin
    overflow_d = overflow_q;
    if (push && fifo_full && !host_rx_ready) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q        <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      gap_q      <= '0;
      x_data_q   <= IDLE_WORD;
    end else begin
      y_q        <= cpu_y_valid;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      x_data_q   <= x_data_d;
    end
  end

  // GAP lasts MIN_GAP-1 cycles, giving strobes MIN_GAP+1 cycles apart.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    x_data_d = x_data_q;
    unique case (state_q)
      IDLE: begin
        if (host_tx_valid) begin
          x_data_d = host_tx_data;
          state_d  = STROBE;
        end
      end
      STROBE: begin
        gap_d   = GW'(MIN_GAP - 1);
        state_d = (MIN_GAP == 1) ? IDLE : GAP;
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_x_valid   = (state_q == STROBE);
    host_tx_ready = (state_q == IDLE);
  end

endmodule
